fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding I-mem request, IF/ID pipeline register, and
// branch-delay-slot aware redirect handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        Stall_IN,
    input  logic [31:0] AltPC_IN,
    input  logic        AltPCEnable_IN,
    output logic        IMemReqValid_OUT,
    output logic [31:0] IMemAddr_OUT,
    input  logic        IMemReqReady_IN,
    input  logic        IMemRespValid_IN,
    input  logic [31:0] IMemRespData_IN,
    output logic [31:0] Instruction_OUT,
    output logic [31:0] InstructionAddressPlus4_OUT,
    output logic        Valid_OUT
);

    typedef enum logic [1:0] {StReq, StWait, StHold} fetchState_t;

    fetchState_t state;
    logic [31:0] pc;
    logic [31:0] reqAddr;
    logic [31:0] holdReg;
    logic [31:0] redirTarget;
    logic        redirPending;
    logic        redirTaken;
    logic        slotIssued;

    logic        accept;
    logic        redirEvent;
    logic        canLoad;
    logic        loadResp;
    logic        loadHold;
    logic [31:0] altPcAligned;
    logic [31:0] reqAddrPlus4;

    // Request is gated by RESET so nothing is issued while reset is being sampled.
    assign IMemReqValid_OUT = RESET && (state == StReq);
    assign IMemAddr_OUT     = pc;

    assign accept       = IMemReqValid_OUT && IMemReqReady_IN;
    assign redirEvent   = Valid_OUT && AltPCEnable_IN && !redirTaken;
    assign canLoad      = !Valid_OUT || !Stall_IN;
    assign loadResp     = (state == StWait) && IMemRespValid_IN && canLoad;
    assign loadHold     = (state == StHold) && !Stall_IN;
    assign altPcAligned = {AltPC_IN[31:2], 2'b00};
    assign reqAddrPlus4 = reqAddr + 32'd4;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state                       <= StReq;
            pc                          <= RESET_PC;
            reqAddr                     <= 32'd0;
            holdReg                     <= 32'd0;
            redirTarget                 <= 32'd0;
            redirPending                <= 1'b0;
            redirTaken                  <= 1'b0;
            slotIssued                  <= 1'b0;
            Instruction_OUT             <= 32'd0;
            InstructionAddressPlus4_OUT <= 32'd0;
            Valid_OUT                   <= 1'b0;
        end else begin
            unique case (state)
                StReq: begin
                    if (accept) begin
                        reqAddr <= pc;
                        state   <= StWait;
                    end
                end
                StWait: begin
                    if (IMemRespValid_IN) begin
                        if (canLoad) begin
                            state <= StReq;
                        end else begin
                            holdReg <= IMemRespData_IN;
                            state   <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (!Stall_IN) begin
                        state <= StReq;
                    end
                end
                default: state <= StReq;
            endcase

            // IF/ID register: load, bubble on a free-running cycle, hold when stalled.
            if (loadResp) begin
                Instruction_OUT             <= IMemRespData_IN;
                InstructionAddressPlus4_OUT <= reqAddrPlus4;
                Valid_OUT                   <= 1'b1;
            end else if (loadHold) begin
                Instruction_OUT             <= holdReg;
                InstructionAddressPlus4_OUT <= reqAddrPlus4;
                Valid_OUT                   <= 1'b1;
            end else if (!Stall_IN) begin
                Instruction_OUT             <= 32'd0;
                InstructionAddressPlus4_OUT <= 32'd0;
                Valid_OUT                   <= 1'b0;
            end

            // A redirect seen before the delay slot is requested is parked until that
            // request is accepted, so the slot is still fetched from the sequential PC.
            if (accept) begin
                if (redirEvent) begin
                    pc <= altPcAligned;
                end else if (redirPending) begin
                    pc           <= redirTarget;
                    redirPending <= 1'b0;
                end else begin
                    pc <= pc + 32'd4;
                end
            end else if (redirEvent) begin
                if (slotIssued) begin
                    pc <= altPcAligned;
                end else begin
                    redirPending <= 1'b1;
                    redirTarget  <= altPcAligned;
                end
            end

            if (accept) begin
                slotIssued <= 1'b1;
            end else if (loadResp || loadHold) begin
                slotIssued <= 1'b0;
            end

            // A fresh IF/ID occupant may redirect again, so the load wins over the event.
            if (loadResp || loadHold) begin
                redirTaken <= 1'b0;
            end else if (redirEvent) begin
                redirTaken <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model of program flow (delay slots, redirects),
// a latency-randomised instruction memory and an ID-stage stub driving redirects.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC00000;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        Stall_IN;
    logic [31:0] AltPC_IN;
    logic        AltPCEnable_IN;
    logic        IMemReqValid_OUT;
    logic [31:0] IMemAddr_OUT;
    logic        IMemReqReady_IN;
    logic        IMemRespValid_IN;
    logic [31:0] IMemRespData_IN;
    logic [31:0] Instruction_OUT;
    logic [31:0] InstructionAddressPlus4_OUT;
    logic        Valid_OUT;

    always #5 CLOCK = ~CLOCK;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLOCK                       (CLOCK),
        .RESET                       (RESET),
        .Stall_IN                    (Stall_IN),
        .AltPC_IN                    (AltPC_IN),
        .AltPCEnable_IN              (AltPCEnable_IN),
        .IMemReqValid_OUT            (IMemReqValid_OUT),
        .IMemAddr_OUT                (IMemAddr_OUT),
        .IMemReqReady_IN             (IMemReqReady_IN),
        .IMemRespValid_IN            (IMemRespValid_IN),
        .IMemRespData_IN             (IMemRespData_IN),
        .Instruction_OUT             (Instruction_OUT),
        .InstructionAddressPlus4_OUT (InstructionAddressPlus4_OUT),
        .Valid_OUT                   (Valid_OUT)
    );

    // Instruction encoding used by the bench: bit 31 marks a taken branch,
    // target = {data[29:0], 2'b00}.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    fetch_t      fetchLog[$];
    fetch_t      delivQ[$];
    logic [31:0] forcedData[$];
    logic [31:0] acceptLog[$];
    fetch_t      flightEntry;
    bit          inFlight = 0;
    int          flightLat = 0;

    logic [31:0] ifidInstr = 32'd0;
    logic [31:0] ifidPlus4 = 32'd0;
    logic        ifidValid = 1'b0;
    bit          brSignaled = 0;

    int vectors = 0;
    int miscompares = 0;

    int stallForce = 0, readyForce = 1;
    int stallPct = 0, readyPct = 100, minLat = 0, maxLat = 0;
    int spurPct = 0, delayPct = 0, resetPct = 0;
    bit resetNow = 0, spurNow = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Program order: fetch k follows k-1 sequentially, except that the fetch two after a
    // branch (i.e. after its delay slot) goes to the branch target.
    function automatic logic [31:0] nextAddr();
        int n;
        n = fetchLog.size();
        if (n == 0) return RESET_PC;
        if (n >= 2 && fetchLog[n-2].data[31]) return {fetchLog[n-2].data[29:0], 2'b00};
        return fetchLog[n-1].addr + 32'd4;
    endfunction

    task automatic genData(output logic [31:0] d);
        bit lastBr;
        lastBr = 0;
        if (fetchLog.size() > 0) lastBr = fetchLog[fetchLog.size()-1].data[31];
        if (forcedData.size() > 0) begin
            d = forcedData.pop_front();
        end else begin
            d = $urandom;
            d[31] = !lastBr && ($urandom_range(3) == 0);
        end
    endtask

    task automatic step();
        logic        respNow, expReqValid, accepted, prevStall, doReset;
        logic [31:0] expAddr;
        fetch_t      e;

        doReset  = resetNow || ($urandom_range(99) < resetPct);
        resetNow = 0;
        RESET    = !doReset;
        Stall_IN = (stallForce >= 0) ? (stallForce == 1) : ($urandom_range(99) < stallPct);
        IMemReqReady_IN = (readyForce >= 0) ? (readyForce == 1)
                                            : ($urandom_range(99) < readyPct);

        // ID stub: may defer a branch's redirect only while the branch is stalled in place.
        if (ifidValid && ifidInstr[31]) begin
            AltPCEnable_IN = brSignaled || !Stall_IN || ($urandom_range(99) >= delayPct);
            AltPC_IN = {ifidInstr[29:0], 2'($urandom_range(3))};
            if (AltPCEnable_IN) brSignaled = 1;
        end else begin
            AltPCEnable_IN = !ifidValid && ($urandom_range(3) == 0);
            AltPC_IN = $urandom;
        end

        respNow = 0;
        if (inFlight) begin
            if (flightLat == 0) respNow = 1;
            else flightLat--;
        end
        IMemRespValid_IN = respNow || (!inFlight && (spurNow || ($urandom_range(99) < spurPct)));
        spurNow = 0;
        IMemRespData_IN = respNow ? flightEntry.data : $urandom;

        #1;
        expReqValid = RESET && !inFlight && (delivQ.size() == 0);
        check("reqValid", {31'd0, IMemReqValid_OUT}, {31'd0, expReqValid});
        accepted = expReqValid && IMemReqReady_IN;
        if (accepted) begin
            expAddr = nextAddr();
            check("fetchAddr", IMemAddr_OUT, expAddr);
            acceptLog.push_back(IMemAddr_OUT);
            e.addr = expAddr;
            genData(e.data);
            fetchLog.push_back(e);
            if (fetchLog.size() > 4) void'(fetchLog.pop_front());
            flightEntry = e;
            inFlight    = 1;
            flightLat   = int'($urandom_range(maxLat, minLat));
        end
        prevStall = Stall_IN;

        @(posedge CLOCK);
        #1;
        if (!RESET) begin
            fetchLog.delete();
            delivQ.delete();
            inFlight   = 0;
            ifidInstr  = 32'd0;
            ifidPlus4  = 32'd0;
            ifidValid  = 1'b0;
            brSignaled = 0;
        end else begin
            if (respNow) begin
                delivQ.push_back(flightEntry);
                inFlight = 0;
            end
            if (delivQ.size() > 0 && (!ifidValid || !prevStall)) begin
                e = delivQ.pop_front();
                ifidInstr  = e.data;
                ifidPlus4  = e.addr + 32'd4;
                ifidValid  = 1'b1;
                brSignaled = 0;
            end else if (!(ifidValid && prevStall)) begin
                ifidInstr  = 32'd0;
                ifidPlus4  = 32'd0;
                ifidValid  = 1'b0;
                brSignaled = 0;
            end
        end
        check("instr", Instruction_OUT, ifidInstr);
        check("plus4", InstructionAddressPlus4_OUT, ifidPlus4);
        check("valid", {31'd0, Valid_OUT}, {31'd0, ifidValid});
        @(negedge CLOCK);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        RESET = 1'b0;
        Stall_IN = 1'b0;
        AltPC_IN = 32'd0;
        AltPCEnable_IN = 1'b0;
        IMemReqReady_IN = 1'b0;
        IMemRespValid_IN = 1'b0;
        IMemRespData_IN = 32'd0;
        @(negedge CLOCK);

        // Reset state.
        resetNow = 1;
        step();
        check("rstValid", {31'd0, Valid_OUT}, 32'd0);

        // Straight-line start, two taken branches and a fetch at the top of memory.
        acceptLog.delete();
        forcedData = '{32'h80100004, 32'h00001111, 32'h80100040, 32'h00002222,
                       32'hBFFFFFFF, 32'h00003333, 32'h00004444};
        stallForce = 0; readyForce = 1; minLat = 0; maxLat = 0;
        step();
        check("firstAddr", acceptLog[0], 32'hBFC00000);
        step();
        check("firstInstr", Instruction_OUT, 32'h80100004);
        check("firstPlus4", InstructionAddressPlus4_OUT, 32'hBFC00004);
        check("firstValid", {31'd0, Valid_OUT}, 32'd1);
        steps(12);
        check("wrapPlus4", InstructionAddressPlus4_OUT, 32'h00000000);
        steps(4);
        check("brAddr2", acceptLog[2], 32'h00400010);
        check("brAddr3", acceptLog[3], 32'h00400014);
        check("brAddr4", acceptLog[4], 32'h00400100);
        check("wrapAddr6", acceptLog[6], 32'hFFFFFFFC);
        check("wrapAddr7", acceptLog[7], 32'h00000000);

        // Response while IF/ID is valid and stalled parks in the hold buffer.
        stallForce = 1;
        steps(4);
        stallForce = 0;
        steps(3);

        // Branch sits stalled in IF/ID with memory not ready: redirect is deferred.
        resetNow = 1;
        step();
        acceptLog.delete();
        forcedData = '{32'h80100004, 32'h00001111};
        stallForce = 0; readyForce = 1;
        step();
        stallForce = 1;
        step();
        readyForce = 0;
        steps(3);
        readyForce = 1;
        steps(2);
        stallForce = 0;
        steps(4);
        check("pendAddr0", acceptLog[0], 32'hBFC00000);
        check("pendAddr1", acceptLog[1], 32'hBFC00004);
        check("pendAddr2", acceptLog[2], 32'h00400010);

        // Reset in WAIT, then a stale response.
        resetNow = 1;
        step();
        acceptLog.delete();
        minLat = 3; maxLat = 3;
        step();
        resetNow = 1;
        step();
        readyForce = 0; spurNow = 1;
        step();
        check("staleValid", {31'd0, Valid_OUT}, 32'd0);
        readyForce = 1;
        step();
        check("rstAddr", acceptLog[1], RESET_PC);

        // Randomised traffic.
        stallForce = -1; readyForce = -1;
        stallPct = 20; readyPct = 80; minLat = 0; maxLat = 0; spurPct = 10; delayPct = 50;
        steps(600);
        stallPct = 50; readyPct = 40; maxLat = 3; spurPct = 20; resetPct = 1;
        steps(800);
        stallPct = 0; readyPct = 100; maxLat = 1; spurPct = 0; delayPct = 0; resetPct = 0;
        steps(400);
        stallPct = 70; readyPct = 60; maxLat = 2; spurPct = 30; delayPct = 70; resetPct = 1;
        steps(800);

        // Drain: everything fetched must reach IF/ID.
        stallForce = 0; readyForce = 0; resetPct = 0;
        steps(8);
        check("drainReqValid", {31'd0, IMemReqValid_OUT}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
